// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the RV32 pipeline MEM stage
package riscv_pipe_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W          = 5;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Control half of the MEM/WB boundary; data fields are zeroed alongside it.
    typedef struct packed {
        logic             reg_write;
        logic             result_src;
        logic [REG_W-1:0] rd;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble load
module mem_wb_reg
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble_i,
    input  wb_ctrl_t          ctrl_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] read_data_i,
    output wb_ctrl_t          ctrl_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] read_data_o
);

    wb_ctrl_t          ctrl_d, ctrl_q;
    logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;
    logic [DATA_W-1:0] alu_result_d, alu_result_q;
    logic [DATA_W-1:0] read_data_d, read_data_q;

    // A bubble retires as an all-zero slot so writeback does nothing with it.
    always_comb begin
        ctrl_d       = ctrl_i;
        pc_plus4_d   = pc_plus4_i;
        alu_result_d = alu_result_i;
        read_data_d  = read_data_i;
        if (bubble_i) begin
            ctrl_d       = WB_CTRL_BUBBLE;
            pc_plus4_d   = '0;
            alu_result_d = '0;
            read_data_d  = '0;
        end
    end

    // Boundary register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q       <= WB_CTRL_BUBBLE;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign pc_plus4_o   = pc_plus4_q;
    assign alu_result_o = alu_result_q;
    assign read_data_o  = read_data_q;

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RV32 MEM stage with variable-latency data bus; DMEM_TIMEOUT_EN adds a WAIT timeout
module memory_cycle
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int STALL_CNT_W    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWriteM,
    input  logic                   MemWriteM,
    input  logic                   ResultSrcM,
    input  logic [REG_W-1:0]       RD_M,
    input  logic [DATA_W-1:0]      PCPlus4M,
    input  logic [DATA_W-1:0]      WriteDataM,
    input  logic [DATA_W-1:0]      ALU_ResultM,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DATA_W-1:0]      dmem_addr,
    output logic [DATA_W-1:0]      dmem_wdata,
    input  logic [DATA_W-1:0]      dmem_rdata,
    input  logic                   dmem_ready,
    output logic                   StallM,
    output logic                   RegWriteW,
    output logic                   ResultSrcW,
    output logic [REG_W-1:0]       RD_W,
    output logic [DATA_W-1:0]      PCPlus4W,
    output logic [DATA_W-1:0]      ALU_ResultW,
    output logic [DATA_W-1:0]      ReadDataW,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   dmem_err
);

    mem_state_e state_q, state_d;
    logic       access;
    logic       expired;
    logic       hold_load;

    logic              hold_we_q;
    logic [DATA_W-1:0] hold_alu_q;
    logic [DATA_W-1:0] hold_wdata_q;
    logic [DATA_W-1:0] hold_pc4_q;
    wb_ctrl_t          hold_ctrl_q;

    logic              wb_bubble;
    wb_ctrl_t          wb_ctrl, wb_ctrl_out;
    logic [DATA_W-1:0] wb_pc4, wb_alu, wb_rdata;

    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign access = MemWriteM | ResultSrcM;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MEM_IDLE;
        else      state_q <= state_d;
    end

    // Next state: park in WAIT only while the memory has not answered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (access && !dmem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready || expired) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // Bus, stall and writeback-source selection; everything is held quiet during reset.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        StallM     = 1'b0;
        hold_load  = 1'b0;
        wb_bubble  = 1'b0;
        wb_ctrl    = '{reg_write: RegWriteM, result_src: ResultSrcM, rd: RD_M};
        wb_pc4     = PCPlus4M;
        wb_alu     = ALU_ResultM;
        wb_rdata   = '0;
        if (rst) begin
            case (state_q)
                MEM_IDLE: begin
                    if (access) begin
                        dmem_req   = 1'b1;
                        dmem_we    = MemWriteM;
                        dmem_addr  = {ALU_ResultM[DATA_W-1:2], 2'b00};
                        dmem_wdata = WriteDataM;
                        StallM     = !dmem_ready;
                        hold_load  = !dmem_ready;
                        wb_bubble  = !dmem_ready;
                        wb_rdata   = ResultSrcM ? dmem_rdata : '0;
                    end
                end
                MEM_WAIT: begin
                    dmem_req   = 1'b1;
                    dmem_we    = hold_we_q;
                    dmem_addr  = {hold_alu_q[DATA_W-1:2], 2'b00};
                    dmem_wdata = hold_wdata_q;
                    // On expiry the pipeline is released and the stalled op is dropped.
                    StallM     = !dmem_ready && !expired;
                    wb_bubble  = !dmem_ready;
                    wb_ctrl    = hold_ctrl_q;
                    wb_pc4     = hold_pc4_q;
                    wb_alu     = hold_alu_q;
                    wb_rdata   = hold_ctrl_q.result_src ? dmem_rdata : '0;
                end
                default: ;
            endcase
        end
    end

    // Hold registers keep the access stable on the bus while EX/MEM is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_we_q    <= 1'b0;
            hold_alu_q   <= '0;
            hold_wdata_q <= '0;
            hold_pc4_q   <= '0;
            hold_ctrl_q  <= WB_CTRL_BUBBLE;
        end else if (hold_load) begin
            hold_we_q    <= MemWriteM;
            hold_alu_q   <= ALU_ResultM;
            hold_wdata_q <= WriteDataM;
            hold_pc4_q   <= PCPlus4M;
            hold_ctrl_q  <= '{reg_write: RegWriteM, result_src: ResultSrcM, rd: RD_M};
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            stall_cnt_q <= '0;
        else if (StallM && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;

`ifdef DMEM_TIMEOUT_EN
    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    // The entry stall cycle counts toward the limit, so expiry lands on the
    // WAIT cycle after TIMEOUT_CYCLES stalls; a ready in that cycle still completes.
    assign expired = (state_q == MEM_WAIT) && (wait_cnt_q == WCNT_LAST);

    // Wait counter restarts on each WAIT entry; the error flag is sticky.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        if (hold_load)
            wait_cnt_d = '0;
        else if (state_q == MEM_WAIT && !expired)
            wait_cnt_d = wait_cnt_q + 1'b1;
        if (expired && !dmem_ready)
            err_d = 1'b1;
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign dmem_err = err_q;
`else
    assign expired  = 1'b0;
    assign dmem_err = 1'b0;
`endif

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .bubble_i     (wb_bubble),
        .ctrl_i       (wb_ctrl),
        .pc_plus4_i   (wb_pc4),
        .alu_result_i (wb_alu),
        .read_data_i  (wb_rdata),
        .ctrl_o       (wb_ctrl_out),
        .pc_plus4_o   (PCPlus4W),
        .alu_result_o (ALU_ResultW),
        .read_data_o  (ReadDataW)
    );

    assign RegWriteW  = wb_ctrl_out.reg_write;
    assign ResultSrcW = wb_ctrl_out.result_src;
    assign RD_W       = wb_ctrl_out.rd;

endmodule
